// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer
//  Purpose  : Steps the PE MAC datapath through one dot product: clear,
//             stream LEN operand addresses, drain memory latency, flag DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [ADDR_W-1:0] BASE_A,
  input  logic [ADDR_W-1:0] BASE_B,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] ADDR_A,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic              PE_CLR,
  output logic              PE_MAC,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] c_drain_last = 3'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_step;
  logic [2:0]          r_drain_cnt;
  logic [ADDR_W-1:0]   r_base_a;
  logic [ADDR_W-1:0]   r_base_b;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic                r_mem_rd;
  logic                r_pe_clr;
  logic                r_busy;
  logic                r_done;
  logic [MEM_LAT-1:0]  r_mac_dly;
  logic                w_in_op;
  logic                w_abort;
  logic                w_last_step;
  logic                w_drain_done;

  assign w_in_op      = (r_state == S_CLEAR) || (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_abort      = ABORT && w_in_op;
  assign w_last_step  = (r_step == (r_len - LEN_W'(1)));
  assign w_drain_done = (r_drain_cnt == c_drain_last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (START && !ABORT) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (ABORT) begin
          w_next_state = S_IDLE;
        end else if (r_len != '0) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_ISSUE: begin
        if (ABORT) begin
          w_next_state = S_IDLE;
        end else if (w_last_step) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          w_next_state = S_IDLE;
        end else if (w_drain_done) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_len       <= '0;
      r_step      <= '0;
      r_drain_cnt <= '0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_mem_rd    <= 1'b0;
      r_pe_clr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_next_state == S_CLEAR)) begin
        r_len    <= LEN;
        r_base_a <= BASE_A;
        r_base_b <= BASE_B;
      end
      if (w_next_state == S_ISSUE) begin
        if (r_state == S_ISSUE) begin
          r_step   <= r_step + LEN_W'(1);
          r_addr_a <= r_addr_a + ADDR_W'(1);
          r_addr_b <= r_addr_b + ADDR_W'(1);
        end else begin
          r_step   <= '0;
          r_addr_a <= r_base_a;
          r_addr_b <= r_base_b;
        end
      end
      if (w_next_state == S_DRAIN) begin
        r_drain_cnt <= (r_state == S_DRAIN) ? (r_drain_cnt + 3'd1) : 3'd0;
      end
      r_mem_rd <= (w_next_state == S_ISSUE);
      r_pe_clr <= (w_next_state == S_CLEAR);
      r_busy   <= (w_next_state == S_CLEAR) || (w_next_state == S_ISSUE) ||
                  (w_next_state == S_DRAIN);
      r_done   <= (w_next_state == S_DONE);
    end
  end

  // Read-strobe delay line; an abort flushes anything still in flight.
  generate
    if (MEM_LAT == 1) begin : g_dly_one
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_mac_dly <= '0;
        end else begin
          r_mac_dly <= w_abort ? 1'b0 : r_mem_rd;
        end
      end
    end else begin : g_dly_multi
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_mac_dly <= '0;
        end else if (w_abort) begin
          r_mac_dly <= '0;
        end else begin
          r_mac_dly <= {r_mac_dly[MEM_LAT-2:0], r_mem_rd};
        end
      end
    end
  endgenerate

  assign MEM_RD = r_mem_rd;
  assign ADDR_A = r_addr_a;
  assign ADDR_B = r_addr_b;
  assign PE_CLR = r_pe_clr;
  assign PE_MAC = r_mac_dly[MEM_LAT-1];
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_sequencer
//  Purpose  : Self-checking bench for mac_sequencer at MEM_LAT=1 and MEM_LAT=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] LEN = 8'd0;
  logic [7:0] BASE_A = 8'd0;
  logic [7:0] BASE_B = 8'd0;

  logic [1:0]      mem_rd, pe_clr, pe_mac, busy, done;
  logic [1:0][7:0] addr_a, addr_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  mac_sequencer #(.ADDR_W(8), .LEN_W(8), .MEM_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .LEN(LEN),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .MEM_RD(mem_rd[0]), .ADDR_A(addr_a[0]),
    .ADDR_B(addr_b[0]), .PE_CLR(pe_clr[0]), .PE_MAC(pe_mac[0]), .BUSY(busy[0]),
    .DONE(done[0])
  );

  mac_sequencer #(.ADDR_W(8), .LEN_W(8), .MEM_LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .LEN(LEN),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .MEM_RD(mem_rd[1]), .ADDR_A(addr_a[1]),
    .ADDR_B(addr_b[1]), .PE_CLR(pe_clr[1]), .PE_MAC(pe_mac[1]), .BUSY(busy[1]),
    .DONE(done[1])
  );

  // Operand memory contents
  function automatic logic [7:0] fa(input logic [7:0] x);
    return x - 8'h0F;
  endfunction

  function automatic logic [7:0] fb(input logic [7:0] x);
    return (x[7:6] == 2'b01) ? 8'd2 : ({5'd0, x[2:0]} + 8'd1);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Behavioural operand memories (per-DUT latency) feeding a PE accumulator
  logic [1:0][3:0][7:0] pa, pb;
  int acc [2] = '{0, 0};

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      pa[k][0] <= mem_rd[k] ? fa(addr_a[k]) : 8'd0;
      pb[k][0] <= mem_rd[k] ? fb(addr_b[k]) : 8'd0;
      for (int j = 1; j < 4; j++) begin
        pa[k][j] <= pa[k][j-1];
        pb[k][j] <= pb[k][j-1];
      end
      if (pe_clr[k]) begin
        acc[k] <= 0;
      end else if (pe_mac[k]) begin
        acc[k] <= acc[k] + int'(pa[k][lat_of(k)-1]) * int'(pb[k][lat_of(k)-1]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: one operation per DUT, outputs derived from cycles since START
  bit         m_act [2];
  int         m_t0 [2], m_len [2], m_sum [2];
  logic [7:0] m_ba [2], m_bb [2], m_addr_a [2], m_addr_b [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int ml, rel, drel;
      bit idle, e_clr, e_rd, e_mac, e_busy, e_done;
      if (RST) begin
        m_act[k]    = 1'b0;
        m_addr_a[k] = 8'd0;
        m_addr_b[k] = 8'd0;
        continue;
      end
      ml     = lat_of(k);
      rel    = cyc - m_t0[k];
      drel   = (m_len[k] == 0) ? 2 : (m_len[k] + ml + 2);
      idle   = !m_act[k];
      e_clr  = m_act[k] && (rel == 1);
      e_rd   = m_act[k] && (rel >= 2) && (rel <= m_len[k] + 1);
      e_mac  = m_act[k] && (rel >= 2 + ml) && (rel <= m_len[k] + 1 + ml);
      e_busy = m_act[k] && (rel >= 1) && (rel < drel);
      e_done = m_act[k] && (rel == drel);
      if (e_rd) begin
        m_addr_a[k] = 8'(int'(m_ba[k]) + rel - 2);
        m_addr_b[k] = 8'(int'(m_bb[k]) + rel - 2);
      end
      chk($sformatf("dut%0d MEM_RD", k), 32'(mem_rd[k]), 32'(e_rd));
      chk($sformatf("dut%0d PE_CLR", k), 32'(pe_clr[k]), 32'(e_clr));
      chk($sformatf("dut%0d PE_MAC", k), 32'(pe_mac[k]), 32'(e_mac));
      chk($sformatf("dut%0d BUSY", k), 32'(busy[k]), 32'(e_busy));
      chk($sformatf("dut%0d DONE", k), 32'(done[k]), 32'(e_done));
      chk($sformatf("dut%0d ADDR_A", k), 32'(addr_a[k]), 32'(m_addr_a[k]));
      chk($sformatf("dut%0d ADDR_B", k), 32'(addr_b[k]), 32'(m_addr_b[k]));
      if (e_done) chk($sformatf("dut%0d ACC", k), acc[k], m_sum[k]);
      if (e_busy && ABORT) m_act[k] = 1'b0;
      if (e_done) m_act[k] = 1'b0;
      if (idle && START && !ABORT) begin
        m_act[k] = 1'b1;
        m_t0[k]  = cyc;
        m_len[k] = int'(LEN);
        m_ba[k]  = BASE_A;
        m_bb[k]  = BASE_B;
        m_sum[k] = 0;
        for (int i = 0; i < int'(LEN); i++) begin
          m_sum[k] += int'(fa(8'(int'(BASE_A) + i))) * int'(fb(8'(int'(BASE_B) + i)));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d MEM_RD", tag, k), 32'(mem_rd[k]), 32'd0);
      chk($sformatf("%s dut%0d PE_CLR", tag, k), 32'(pe_clr[k]), 32'd0);
      chk($sformatf("%s dut%0d PE_MAC", tag, k), 32'(pe_mac[k]), 32'd0);
      chk($sformatf("%s dut%0d BUSY", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s dut%0d DONE", tag, k), 32'(done[k]), 32'd0);
      chk($sformatf("%s dut%0d ADDR_A", tag, k), 32'(addr_a[k]), 32'd0);
      chk($sformatf("%s dut%0d ADDR_B", tag, k), 32'(addr_b[k]), 32'd0);
    end
  endtask

  task automatic launch(input logic [7:0] len, input logic [7:0] ba, input logic [7:0] bb);
    START  = 1'b1;
    LEN    = len;
    BASE_A = ba;
    BASE_B = bb;
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    chk_all_zero("reset");
    #2 RST = 1'b0;
    repeat (2) tick();

    // Basic run: LEN=4, A=0x10.., B=0x40..
    launch(8'd4, 8'h10, 8'h40);
    tick();                                   // cycle 1
    START = 1'b0;
    chk("basic PE_CLR c1", 32'(pe_clr[0]), 32'd1);
    tick();                                   // cycle 2
    chk("basic MEM_RD c2", 32'(mem_rd[0]), 32'd1);
    chk("basic ADDR_A c2", 32'(addr_a[0]), 32'h10);
    chk("basic ADDR_B c2", 32'(addr_b[0]), 32'h40);
    chk("basic PE_MAC c2", 32'(pe_mac[0]), 32'd0);
    tick();                                   // cycle 3
    chk("basic PE_MAC c3", 32'(pe_mac[0]), 32'd1);
    repeat (2) tick();                        // cycle 5
    chk("basic ADDR_A c5", 32'(addr_a[0]), 32'h13);
    chk("basic ADDR_B c5", 32'(addr_b[0]), 32'h43);
    tick();                                   // cycle 6
    chk("basic MEM_RD c6", 32'(mem_rd[0]), 32'd0);
    chk("basic PE_MAC c6", 32'(pe_mac[0]), 32'd1);
    chk("basic ADDR_A hold c6", 32'(addr_a[0]), 32'h13);
    tick();                                   // cycle 7
    chk("basic DONE lat1 c7", 32'(done[0]), 32'd1);
    chk("basic ACC lat1", acc[0], 32'd20);
    repeat (2) tick();                        // cycle 9
    chk("basic DONE lat3 c9", 32'(done[1]), 32'd1);
    chk("basic ACC lat3", acc[1], 32'd20);
    repeat (3) tick();

    // Address wrap-around
    launch(8'd4, 8'hFE, 8'h00);
    tick();
    START = 1'b0;
    tick();  chk("wrap ADDR_A s0", 32'(addr_a[0]), 32'hFE);
    tick();  chk("wrap ADDR_A s1", 32'(addr_a[0]), 32'hFF);
    tick();  chk("wrap ADDR_A s2", 32'(addr_a[0]), 32'h00);
    tick();  chk("wrap ADDR_A s3", 32'(addr_a[0]), 32'h01);
    chk("wrap ADDR_B s3", 32'(addr_b[0]), 32'h03);
    repeat (6) tick();

    // LEN=0
    launch(8'd0, 8'h20, 8'h30);
    tick();
    START = 1'b0;
    chk("len0 PE_CLR lat1", 32'(pe_clr[0]), 32'd1);
    chk("len0 PE_CLR lat3", 32'(pe_clr[1]), 32'd1);
    tick();
    chk("len0 DONE lat1 c2", 32'(done[0]), 32'd1);
    chk("len0 DONE lat3 c2", 32'(done[1]), 32'd1);
    chk("len0 ACC lat1", acc[0], 32'd0);
    chk("len0 ACC lat3", acc[1], 32'd0);
    repeat (3) tick();

    // MEM_LAT=3, LEN=2 with START held high
    launch(8'd2, 8'h50, 8'h58);
    repeat (4) tick();                        // cycle 4
    chk("lat3 PE_MAC c4", 32'(pe_mac[1]), 32'd0);
    tick();  chk("lat3 PE_MAC c5", 32'(pe_mac[1]), 32'd1);
    tick();  chk("lat3 PE_MAC c6", 32'(pe_mac[1]), 32'd1);
    tick();  chk("lat3 DONE c7", 32'(done[1]), 32'd1);
    chk("lat3 PE_MAC c7", 32'(pe_mac[1]), 32'd0);
    tick();  chk("lat3 PE_CLR c8", 32'(pe_clr[1]), 32'd0);
    chk("lat3 BUSY c8", 32'(busy[1]), 32'd0);
    tick();  chk("lat3 restart PE_CLR c9", 32'(pe_clr[1]), 32'd1);
    START = 1'b0;
    repeat (10) tick();

    // START and ABORT together in IDLE
    launch(8'd3, 8'h00, 8'h00);
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("idle abort BUSY", 32'(busy[0]), 32'd0);
    chk("idle abort PE_CLR", 32'(pe_clr[0]), 32'd0);
    repeat (2) tick();

    // ABORT in second ISSUE cycle
    launch(8'd8, 8'h80, 8'h88);
    tick();
    START = 1'b0;
    repeat (2) tick();                        // cycle 3
    ABORT = 1'b1;
    tick();                                   // cycle 4
    ABORT = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort dut%0d BUSY", k), 32'(busy[k]), 32'd0);
      chk($sformatf("abort dut%0d MEM_RD", k), 32'(mem_rd[k]), 32'd0);
      chk($sformatf("abort dut%0d PE_MAC", k), 32'(pe_mac[k]), 32'd0);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(done[0]) + int'(done[1]) + int'(mem_rd[0]) + int'(mem_rd[1]) +
             int'(pe_mac[0]) + int'(pe_mac[1]);
    end
    chk("abort quiet 20 cycles", cnt, 32'd0);

    // Asynchronous reset mid-DRAIN
    launch(8'd2, 8'h60, 8'h70);
    tick();
    START = 1'b0;
    repeat (4) tick();                        // cycle 5
    chk("drain BUSY lat3", 32'(busy[1]), 32'd1);
    chk("drain MEM_RD lat3", 32'(mem_rd[1]), 32'd0);
    #2 RST = 1'b1;
    #1 chk_all_zero("async rst");
    tick();
    #2 RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(done[0]) + int'(done[1]);
    end
    chk("post-reset no DONE", cnt, 32'd0);

    // Fresh LEN=1 after reset
    launch(8'd1, 8'h33, 8'h44);
    tick();
    START = 1'b0;
    repeat (3) tick();                        // cycle 4
    chk("len1 DONE lat1 c4", 32'(done[0]), 32'd1);
    chk("len1 ACC lat1", acc[0], 32'd72);
    repeat (2) tick();                        // cycle 6
    chk("len1 DONE lat3 c6", 32'(done[1]), 32'd1);
    chk("len1 ACC lat3", acc[1], 32'd72);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
